// File: rtl/jump_controller.sv
// Button synchroniser/debouncer feeding a jump FSM with a landing watchdog and a saturating jump counter.
// Optional `JUMP_BUFFER_EN`: a one-deep buffer holds a press made during a flight and issues it on landing.
module jump_controller #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int LAND_TIMEOUT_MS = 120,
  parameter int COUNT_WIDTH     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   module_en,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   one_ms_tick,
  input  logic                   landed,
  output logic                   jump_left,
  output logic                   jump_right,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] jump_count,
  output logic                   land_timeout,
  output logic                   dbg_state
);

  localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam int WD_W = $clog2(LAND_TIMEOUT_MS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LAND_TIMEOUT_MS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FLIGHT = 1'b1} state_t;

  // Bit 0 is the left button, bit 1 the right button throughout.
  logic [1:0]      w_btn;
  logic [1:0]      r_meta;
  logic [1:0]      r_sync;
  logic [1:0]      r_stable;
  logic [1:0]      r_stable_q;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      w_press;

  assign w_btn   = {btn_right, btn_left};
  assign w_press = r_stable & ~r_stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_meta     <= w_btn;
      r_sync     <= r_meta;
      r_stable_q <= r_stable;
      for (int b = 0; b < 2; b++) begin
        if (r_sync[b] == r_stable[b]) begin
          r_db_cnt[b] <= '0;
        end else if (one_ms_tick) begin
          if (r_db_cnt[b] == DB_LAST) begin
            r_stable[b] <= ~r_stable[b];
            r_db_cnt[b] <= '0;
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
          end
        end
      end
    end
  end

  state_t                 r_state, w_state_n;
  logic                   r_jump_left, w_jump_left_n;
  logic                   r_jump_right, w_jump_right_n;
  logic                   r_busy, w_busy_n;
  logic [COUNT_WIDTH-1:0] r_count, w_count_n;
  logic                   r_land_to, w_land_to_n;
  logic [WD_W-1:0]        r_wd, w_wd_n;
`ifdef JUMP_BUFFER_EN
  logic                   r_buf_valid, w_buf_valid_n;
  logic                   r_buf_right, w_buf_right_n;
`endif

  always_comb begin
    w_state_n      = r_state;
    w_jump_left_n  = 1'b0;
    w_jump_right_n = 1'b0;
    w_busy_n       = r_busy;
    w_count_n      = r_count;
    w_land_to_n    = 1'b0;
    w_wd_n         = r_wd;
`ifdef JUMP_BUFFER_EN
    w_buf_valid_n  = r_buf_valid;
    w_buf_right_n  = r_buf_right;
`endif
    case (r_state)
      S_IDLE: begin
        if (module_en && (|w_press)) begin
          w_jump_left_n  = w_press[0];
          w_jump_right_n = ~w_press[0];
          w_busy_n       = 1'b1;
          w_wd_n         = '0;
          w_state_n      = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
`ifdef JUMP_BUFFER_EN
        // No capture while a command is on the wire, so a landing on the very next
        // cycle cannot produce two back-to-back command pulses.
        if (module_en && !r_buf_valid && !(r_jump_left || r_jump_right) && (|w_press)) begin
          w_buf_valid_n = 1'b1;
          w_buf_right_n = ~w_press[0];
        end
`endif
        if (landed) begin
          if (r_count != '1) w_count_n = r_count + COUNT_WIDTH'(1);
`ifdef JUMP_BUFFER_EN
          w_buf_valid_n = 1'b0;
          if (r_buf_valid) begin
            w_jump_left_n  = ~r_buf_right;
            w_jump_right_n = r_buf_right;
            w_wd_n         = '0;
          end else begin
            w_busy_n  = 1'b0;
            w_state_n = S_IDLE;
          end
`else
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
`endif
        end else if (one_ms_tick) begin
          if (r_wd == WD_LAST) begin
            w_land_to_n = 1'b1;
            w_busy_n    = 1'b0;
            w_wd_n      = '0;
            w_state_n   = S_IDLE;
`ifdef JUMP_BUFFER_EN
            w_buf_valid_n = 1'b0;
`endif
          end else begin
            w_wd_n = r_wd + WD_W'(1);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_jump_left  <= 1'b0;
      r_jump_right <= 1'b0;
      r_busy       <= 1'b0;
      r_count      <= '0;
      r_land_to    <= 1'b0;
      r_wd         <= '0;
`ifdef JUMP_BUFFER_EN
      r_buf_valid  <= 1'b0;
      r_buf_right  <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_jump_left  <= w_jump_left_n;
      r_jump_right <= w_jump_right_n;
      r_busy       <= w_busy_n;
      r_count      <= w_count_n;
      r_land_to    <= w_land_to_n;
      r_wd         <= w_wd_n;
`ifdef JUMP_BUFFER_EN
      r_buf_valid  <= w_buf_valid_n;
      r_buf_right  <= w_buf_right_n;
`endif
    end
  end

  assign jump_left    = r_jump_left;
  assign jump_right   = r_jump_right;
  assign busy         = r_busy;
  assign jump_count   = r_count;
  assign land_timeout = r_land_to;
  assign dbg_state    = (r_state == S_FLIGHT);

endmodule

// File: tb/tb_jump_controller.sv
// Bench for jump_controller: scenario tasks plus randomized traffic, checked against a cycle model
// built from the behavioural rules (debounce by tick counting, flight/watchdog by plain integers).
module tb_jump_controller;
  localparam int D      = 2;
  localparam int TO     = 100;
  localparam int CW     = 2;
  localparam int TICK_P = 10;
  localparam int CMAX   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic module_en = 1'b1;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic one_ms_tick = 1'b0;
  logic landed = 1'b0;
  logic jump_left, jump_right, busy, land_timeout, dbg_state;
  logic [CW-1:0] jump_count;

  jump_controller #(.DEBOUNCE_MS(D), .LAND_TIMEOUT_MS(TO), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .btn_left(btn_left), .btn_right(btn_right),
    .one_ms_tick(one_ms_tick), .landed(landed), .jump_left(jump_left), .jump_right(jump_right),
    .busy(busy), .jump_count(jump_count), .land_timeout(land_timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_stable [2];
  bit m_stable_q [2];
  int m_dcnt [2];
  bit m_flight;
  int m_wd;
  bit m_buf_v;
  bit m_buf_right;
  bit e_jl, e_jr, e_busy, e_to;
  int e_count;

  task automatic model_edge();
    bit btn [2];
    bit pl, pr, was_buf;
`ifdef JUMP_BUFFER_EN
    bit pulse_now;
    pulse_now = e_jl || e_jr;
`endif
    btn[0] = btn_left;
    btn[1] = btn_right;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; m_stable_q[b] = 0; m_dcnt[b] = 0;
      end
      m_flight = 0; m_wd = 0; m_buf_v = 0; m_buf_right = 0;
      e_jl = 0; e_jr = 0; e_busy = 0; e_to = 0; e_count = 0;
      return;
    end
    pl = m_stable[0] && !m_stable_q[0];
    pr = m_stable[1] && !m_stable_q[1];
    was_buf = m_buf_v;
    e_jl = 0; e_jr = 0; e_to = 0;
    if (!m_flight) begin
      if (module_en && (pl || pr)) begin
        e_jl = pl; e_jr = !pl; e_busy = 1; m_wd = 0; m_flight = 1;
      end
    end else begin
`ifdef JUMP_BUFFER_EN
      if (module_en && !m_buf_v && !pulse_now && (pl || pr)) begin
        m_buf_v = 1; m_buf_right = !pl;
      end
`endif
      if (landed) begin
        e_count = (e_count < CMAX) ? e_count + 1 : CMAX;
        m_buf_v = 0;
        if (was_buf) begin
          e_jl = !m_buf_right; e_jr = m_buf_right; m_wd = 0;
        end else begin
          m_flight = 0; e_busy = 0;
        end
      end else if (one_ms_tick) begin
        m_wd++;
        if (m_wd >= TO) begin
          e_to = 1; e_busy = 0; m_flight = 0; m_buf_v = 0;
        end
      end
    end
    for (int b = 0; b < 2; b++) begin
      m_stable_q[b] = m_stable[b];
      if (m_s2[b] == m_stable[b]) m_dcnt[b] = 0;
      else if (one_ms_tick) begin
        m_dcnt[b]++;
        if (m_dcnt[b] == D) begin
          m_stable[b] = !m_stable[b];
          m_dcnt[b] = 0;
        end
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = btn[b];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    one_ms_tick = (cyc % TICK_P == TICK_P - 1);
  endtask

  function automatic logic [CW+4:0] obs_vec();
    return {jump_left, jump_right, busy, land_timeout, dbg_state, jump_count};
  endfunction

  function automatic logic [CW+4:0] exp_vec();
    return {e_jl, e_jr, e_busy, e_to, m_flight, e_count[CW-1:0]};
  endfunction

  task automatic press_release(input bit l, input bit r, input int hold, output int nl, output int nr);
    nl = 0; nr = 0;
    btn_left = l; btn_right = r;
    repeat (hold) begin step(); nl += int'(jump_left); nr += int'(jump_right); end
    btn_left = 0; btn_right = 0;
    repeat (30) begin step(); nl += int'(jump_left); nr += int'(jump_right); end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (5) begin
      btn_left = 1'($urandom_range(0, 1)); btn_right = 1'($urandom_range(0, 1));
      landed = 1'($urandom_range(0, 1));
      step();
    end
    n_cmp++; if (jump_left !== 1'b0) begin n_fail++; $display("FAIL reset_jump_left got=%b exp=0", jump_left); end
    n_cmp++; if (jump_right !== 1'b0) begin n_fail++; $display("FAIL reset_jump_right got=%b exp=0", jump_right); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (jump_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", jump_count); end
    n_cmp++; if (land_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", land_timeout); end
    rst = 0; btn_left = 0; btn_right = 0; landed = 0; module_en = 1;
    repeat (30) begin
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
    end
  endtask

  task automatic test_debounce_press();
    int pulses = 0;
    int lat = -1;
    int right_seen = 0;
    btn_left = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL debounce_cycle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
      if (jump_left) begin pulses++; if (lat < 0) lat = i + 1; end
      if (jump_right) right_seen++;
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL debounce_pulse_count got=%0d exp=1", pulses); end
    n_cmp++;
    if (lat < 2 + (D - 1) * TICK_P + 2 || lat > 2 + D * TICK_P + 2) begin
      n_fail++; $display("FAIL debounce_latency got=%0d exp=%0d..%0d", lat, 2 + (D - 1) * TICK_P + 2, 2 + D * TICK_P + 2);
    end
    n_cmp++; if (right_seen != 0) begin n_fail++; $display("FAIL debounce_no_right got=%0d exp=0", right_seen); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL debounce_busy got=%b exp=1", busy); end
    btn_left = 0;
    pulses = 0;
    repeat (40) begin
      step();
      if (jump_left || jump_right) pulses++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL release_cycle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL release_no_event got=%0d exp=0", pulses); end
  endtask

  task automatic test_land_count();
    int n_ticks = 0;
    int guard = 0;
    while (n_ticks < 80 && guard < 2000) begin
      if (one_ms_tick) n_ticks++;
      step(); guard++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL flight_cycle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
    end
    landed = 1; step(); landed = 0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL land_busy got=%b exp=0", busy); end
    n_cmp++; if (jump_count !== CW'(1)) begin n_fail++; $display("FAIL land_count got=%0d exp=1", jump_count); end
    n_cmp++; if (land_timeout !== 1'b0) begin n_fail++; $display("FAIL land_no_timeout got=%b exp=0", land_timeout); end
  endtask

  task automatic test_timeout();
    int nl, nr;
    int to_seen = 0;
    int after = 0;
    press_release(1, 0, 30, nl, nr);
    n_cmp++; if (nl != 1) begin n_fail++; $display("FAIL timeout_issue got=%0d exp=1", nl); end
    for (int i = 0; i < 1200 && after < 3; i++) begin
      step();
      if (land_timeout) to_seen++;
      if (to_seen > 0) after++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL timeout_cycle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
    end
    n_cmp++; if (to_seen != 1) begin n_fail++; $display("FAIL timeout_pulses got=%0d exp=1", to_seen); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    n_cmp++; if (jump_count !== CW'(1)) begin n_fail++; $display("FAIL timeout_count got=%0d exp=1", jump_count); end
  endtask

  task automatic test_landed_vs_timeout();
    int nl, nr;
    int guard = 0;
    int to_seen = 0;
    press_release(1, 0, 30, nl, nr);
    while (!(m_flight && m_wd == TO - 1 && one_ms_tick) && guard < 1500) begin
      step(); guard++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL coincide_cycle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
    end
    n_cmp++; if (guard >= 1500) begin n_fail++; $display("FAIL coincide_wait got=%0d exp=<1500", guard); end
    landed = 1; step(); landed = 0;
    n_cmp++; if (jump_count !== CW'(2)) begin n_fail++; $display("FAIL coincide_count got=%0d exp=2", jump_count); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coincide_busy got=%b exp=0", busy); end
    repeat (5) begin step(); if (land_timeout) to_seen++; end
    n_cmp++; if (to_seen != 0 || land_timeout !== 1'b0) begin n_fail++; $display("FAIL coincide_no_timeout got=%0d exp=0", to_seen); end
  endtask

  task automatic test_glitch();
    int nr = 0;
    btn_right = 1;
    repeat (10) begin step(); nr += int'(jump_right); end
    btn_right = 0;
    repeat (40) begin
      step(); nr += int'(jump_right);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL glitch_cycle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
    end
    n_cmp++; if (nr != 0) begin n_fail++; $display("FAIL glitch_no_right got=%0d exp=0", nr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask

  task automatic test_simultaneous();
    int nl, nr;
    press_release(1, 1, 30, nl, nr);
    n_cmp++; if (nl != 1 || nr != 0) begin n_fail++; $display("FAIL both_left_wins got=%0d/%0d exp=1/0", nl, nr); end
    n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL both_state got=%b exp=%b", obs_vec(), exp_vec()); end
    landed = 1; step(); landed = 0;
    n_cmp++; if (jump_count !== CW'(3)) begin n_fail++; $display("FAIL both_count got=%0d exp=3", jump_count); end
  endtask

  task automatic test_disabled();
    int nl, nr;
    module_en = 0;
    press_release(1, 0, 30, nl, nr);
    n_cmp++; if (nl != 0 || nr != 0) begin n_fail++; $display("FAIL disabled_no_pulse got=%0d/%0d exp=0/0", nl, nr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL disabled_busy got=%b exp=0", busy); end
    module_en = 1;
  endtask

  task automatic test_buffer();
    int nl, nr;
    press_release(1, 0, 30, nl, nr);
    press_release(0, 1, 30, nl, nr);
    n_cmp++; if (nr != 0) begin n_fail++; $display("FAIL buffer_held got=%0d exp=0", nr); end
    landed = 1; step(); landed = 0;
`ifdef JUMP_BUFFER_EN
    n_cmp++; if (jump_right !== 1'b1) begin n_fail++; $display("FAIL buffer_issue got=%b exp=1", jump_right); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL buffer_busy got=%b exp=1", busy); end
`else
    n_cmp++; if (jump_right !== 1'b0) begin n_fail++; $display("FAIL buffer_issue got=%b exp=0", jump_right); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL buffer_busy got=%b exp=0", busy); end
`endif
    step();
    n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL buffer_after got=%b exp=%b", obs_vec(), exp_vec()); end
    if (m_flight) begin landed = 1; step(); landed = 0; end
  endtask

  task automatic test_saturate();
    int nl, nr;
    press_release(0, 1, 30, nl, nr);
    n_cmp++; if (nr != 1) begin n_fail++; $display("FAIL sat_issue got=%0d exp=1", nr); end
    landed = 1; step(); landed = 0;
    n_cmp++; if (jump_count !== CW'(CMAX)) begin n_fail++; $display("FAIL sat_count got=%0d exp=%0d", jump_count, CMAX); end
  endtask

  task automatic test_random();
    bit prev_pulse = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 24) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 99) == 0) module_en = ~module_en;
      landed = ($urandom_range(0, 39) == 0);
      step();
      landed = 0;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_cycle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
      n_cmp++;
      if ((jump_left && jump_right) || ((jump_left || jump_right) && prev_pulse)) begin
        n_fail++; $display("FAIL random_pulse_rule cyc=%0d got=%b%b prev=%b exp=exclusive,non-consecutive", cyc, jump_left, jump_right, prev_pulse);
      end
      prev_pulse = jump_left || jump_right;
    end
    btn_left = 0; btn_right = 0; module_en = 1;
    repeat (40) step();
  endtask

  task automatic test_reset_midflight();
    int nl, nr;
    if (m_flight) begin landed = 1; step(); landed = 0; end
    press_release(1, 0, 30, nl, nr);
    rst = 1; step(); rst = 0;
    n_cmp++; if (busy !== 1'b0 || dbg_state !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got=%b%b exp=00", busy, dbg_state); end
    n_cmp++; if (jump_count !== '0) begin n_fail++; $display("FAIL midreset_count got=%0d exp=0", jump_count); end
    repeat (10) begin
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL midreset_cycle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_debounce_press();
    test_land_count();
    test_timeout();
    test_landed_vs_timeout();
    test_glitch();
    test_simultaneous();
    test_disabled();
    test_buffer();
    test_saturate();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
